// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard controller beside the ID stage of the 5-stage RV32 pipeline.
//   It keeps a shadow scoreboard of the EX/MEM/WB destination registers.
//   It resolves RAW hazards three ways:
//     - forwarding, with priority EX > MEM > WB;
//     - load-use stalls, LOAD_LAT cycles long;
//     - branch-taken flushes.
//   All control outputs are combinational, so a hazard decision has zero
//   cycles of latency.
//
// Ports
//   clk, rst_n               clock; rst_n is asynchronous and ACTIVE-HIGH
//   ID_rs1/2, ID_re1/2       ID source registers and their read enables
//   ID_waddr, ID_rf_we       ID destination register and its write enable
//   ID_is_load               ID instruction is a load
//   EX_result, MEM_wd, WB_wd candidate forwarding data
//   EX_br_taken              branch/jump in EX redirects the PC
//   stall_pc, stall_if_id    hold the PC and the IF/ID register
//   flush_if_id, flush       clear IF/ID; insert a bubble into ID/EX
//   rd1_op/rd2_op            use the forwarded operand
//   rd1_f/rd2_f              forwarded operand values
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   Adds the counters stall_cnt and flush_cnt.
//   stall_cnt counts cycles with stall_pc = 1.
//   flush_cnt counts cycles with flush_if_id = 1.
//   Both counters wrap.
module hazard_fwd_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ID_rs1,
    input  logic [AW-1:0] ID_rs2,
    input  logic          ID_re1,
    input  logic          ID_re2,
    input  logic [AW-1:0] ID_waddr,
    input  logic          ID_rf_we,
    input  logic          ID_is_load,
    input  logic [DW-1:0] EX_result,
    input  logic [DW-1:0] MEM_wd,
    input  logic [DW-1:0] WB_wd,
    input  logic          EX_br_taken,
    output logic          stall_pc,
    output logic          stall_if_id,
    output logic          flush_if_id,
    output logic          flush,
    output logic          rd1_op,
    output logic          rd2_op,
    output logic [DW-1:0] rd1_f,
    output logic [DW-1:0] rd2_f
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;

    // Scoreboard entries, one per downstream stage
    logic [AW-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic          ex_we, mem_we, wb_we;
    logic          ex_ld, mem_ld, wb_ld;

    logic          ex_vld, mem_vld, wb_vld;
    logic          load_use;
    logic          stall_c, flush_c, flush_if_id_c, mask_ld;
    logic [DW:0]   fwd1, fwd2;

    assign ex_vld  = ex_we  && (ex_waddr  != '0);
    assign mem_vld = mem_we && (mem_waddr != '0);
    assign wb_vld  = wb_we  && (wb_waddr  != '0);

    assign load_use = ex_vld && ex_ld &&
                      ((ID_re1 && ID_rs1 == ex_waddr) || (ID_re2 && ID_rs2 == ex_waddr));

    // Returns {op, data}.
    // A matching load in EX blocks lower stages instead of falling through:
    // the youngest writer always wins, even when it cannot forward yet.
    function automatic logic [DW:0] fwd_sel(input logic re, input logic [AW-1:0] rs,
                                            input logic mask);
        fwd_sel = '0;
        if (re && ex_vld && rs == ex_waddr) begin
            if (!ex_ld) fwd_sel = {1'b1, EX_result};
        end else if (re && mem_vld && rs == mem_waddr) begin
            if (!(mask && mem_ld)) fwd_sel = {1'b1, MEM_wd};
        end else if (re && wb_vld && rs == wb_waddr) begin
            if (!(mask && wb_ld)) fwd_sel = {1'b1, WB_wd};
        end
    endfunction

    // Next-state and raw control decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stall_c       = 1'b0;
        flush_c       = 1'b0;
        flush_if_id_c = 1'b0;
        mask_ld       = 1'b0;
        if (EX_br_taken) begin
            // The ID instruction is squashed, so a pending load-use is moot
            flush_if_id_c = 1'b1;
            flush_c       = 1'b1;
            state_nxt     = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        stall_c = 1'b1;
                        flush_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            cnt_nxt   = 2'(LOAD_LAT - 1);
                            state_nxt = STALL;
                        end
                    end
                end
                STALL: begin
                    stall_c = 1'b1;
                    flush_c = 1'b1;
                    mask_ld = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt <= 2'd1) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign fwd1 = fwd_sel(ID_re1, ID_rs1, mask_ld);
    assign fwd2 = fwd_sel(ID_re2, ID_rs2, mask_ld);

    // Outputs are forced low while reset is held, without waiting for an edge
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush       = 1'b0;
        rd1_op      = 1'b0;
        rd2_op      = 1'b0;
        rd1_f       = '0;
        rd2_f       = '0;
        if (!rst_n) begin
            stall_pc    = stall_c;
            stall_if_id = stall_c;
            flush_if_id = flush_if_id_c;
            flush       = flush_c;
            rd1_op      = fwd1[DW];
            rd2_op      = fwd2[DW];
            rd1_f       = fwd1[DW-1:0];
            rd2_f       = fwd2[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ID -> EX -> MEM -> WB scoreboard shift; a flush enters a bubble
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            {ex_waddr, ex_we, ex_ld}    <= '0;
            {mem_waddr, mem_we, mem_ld} <= '0;
            {wb_waddr, wb_we, wb_ld}    <= '0;
        end else begin
            {wb_waddr, wb_we, wb_ld}    <= {mem_waddr, mem_we, mem_ld};
            {mem_waddr, mem_we, mem_ld} <= {ex_waddr, ex_we, ex_ld};
            if (flush_c)
                {ex_waddr, ex_we, ex_ld} <= '0;
            else
                {ex_waddr, ex_we, ex_ld} <= {ID_waddr, ID_rf_we, ID_is_load};
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc)    stall_cnt <= stall_cnt + 32'd1;
            if (flush_if_id) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
